regbank_initiator: RTL and testbench

Command-driven controller that drives the write port and first read port of the team's register bank (N×W, address 0 reads as zero). It accepts single WRITE, READ and multi-address FILL commands over a valid/ready interface and sequences the bank accesses. It returns exactly one response per command. It sits between the lab test harness/host logic and the register bank, and is the bank's only writer.

---
 rtl/regbank_pkg.sv | 30 +++
 rtl/regbank_initiator_if.sv | 33 +++
 rtl/regbank_addr_ctr.sv | 43 ++++
 rtl/regbank_initiator.sv | 176 +++++++++++++++++
 tb/tb_regbank_initiator.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regbank_pkg
// Brief    : Shared types and constants for the register bank initiator.
// Revision : 1.0  initial release
// ============================================================================
package regbank_pkg;

    localparam int c_ADDR_W = 5;
    localparam int c_DEF_N  = 32;
    localparam int c_DEF_W  = 16;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_FILL   = 3'd2,
        ST_READ   = 3'd3,
        ST_VERIFY = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/regbank_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : regbank_initiator_if
// Brief    : Command / response handshake bundle between host and initiator.
// Revision : 1.0  initial release
// ============================================================================
interface regbank_initiator_if
    import regbank_pkg::*;
#(
    parameter int W = c_DEF_W
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [c_ADDR_W-1:0] cmd_addr;
    logic [c_ADDR_W-1:0] cmd_len;
    logic [W-1:0]        cmd_data;
    logic                resp_valid;
    logic                resp_ready;
    logic [W-1:0]        resp_data;
    logic                resp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, resp_ready,
        input  cmd_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, resp_ready,
        output cmd_ready, resp_valid, resp_data, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/regbank_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module   : regbank_addr_ctr
// Brief    : Loadable bank address counter, wraps N-1 -> 0, flags last write.
// Revision : 1.0  initial release
// ============================================================================
module regbank_addr_ctr
    import regbank_pkg::*;
#(
    parameter int N = c_DEF_N
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_load,
    input  wire logic [c_ADDR_W-1:0] i_start,
    input  wire logic [c_ADDR_W-1:0] i_len,
    input  wire logic                i_step,
    output logic [c_ADDR_W-1:0]      o_addr,
    output logic                     o_last
);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(N - 1);
    localparam logic [c_ADDR_W-1:0] c_ONE       = c_ADDR_W'(1);

    logic [c_ADDR_W-1:0] r_addr;
    logic [c_ADDR_W-1:0] r_left;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_left <= '0;
        end else if (i_load) begin
            r_addr <= i_start;
            r_left <= i_len;
        end else if (i_step) begin
            r_addr <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + c_ONE;
            r_left <= r_left - c_ONE;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_left == '0);
endmodule
`default_nettype wire

// File: rtl/regbank_initiator.sv
`default_nettype none
// ============================================================================
// Module   : regbank_initiator
// Brief    : Sequences WRITE/READ/FILL commands onto the register bank ports,
//            one response per command. Define REGBANK_WRITE_VERIFY_EN to add
//            a read-back VERIFY cycle after every bank write.
// Revision : 1.0  initial release
// ============================================================================
module regbank_initiator
    import regbank_pkg::*;
#(
    parameter int N = c_DEF_N,
    parameter int W = c_DEF_W
) (
    input  wire logic                clk,
    input  wire logic                rst,
    regbank_initiator_if.slave       host,
    output logic [c_ADDR_W-1:0]      bank_addr_rd,
    output logic [W-1:0]             bank_data_in,
    output logic                     bank_we,
    output logic [c_ADDR_W-1:0]      bank_addr_rs1,
    input  wire logic [W-1:0]        bank_rs1,
    output logic                     busy
);
    localparam logic [31:0] c_N = N;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [W-1:0]        r_wdata;
    logic [c_ADDR_W-1:0] r_rd_addr;
    logic [W-1:0]        r_resp_data;
    logic                r_resp_err;

    op_e                 w_op;
    logic                w_reject;
    logic                w_accept;
    logic                w_ctr_load;
    logic                w_ctr_step;
    logic [c_ADDR_W-1:0] w_ctr_len;
    logic [c_ADDR_W-1:0] w_ctr_addr;
    logic                w_ctr_last;

    assign w_op     = op_e'(host.cmd_op);
    assign w_reject = (w_op == OP_RSVD) ||
                      ({{(32 - c_ADDR_W){1'b0}}, host.cmd_addr} >= c_N);

    // Ready is forced low while reset is held so nothing is taken mid-reset.
    assign host.cmd_ready  = (r_state == ST_IDLE) && !rst;
    assign w_accept        = host.cmd_valid && host.cmd_ready;
    assign host.resp_valid = (r_state == ST_RESP);
    assign host.resp_data  = r_resp_data;
    assign host.resp_err   = r_resp_err;
    assign busy            = (r_state != ST_IDLE);

    // The counter only moves on WRITE/FILL, so the write port holds its last value.
    assign bank_we      = (r_state == ST_WRITE) || (r_state == ST_FILL);
    assign bank_addr_rd = w_ctr_addr;
    assign bank_data_in = r_wdata;

`ifdef REGBANK_WRITE_VERIFY_EN
    logic [W-1:0] w_expect;
    assign w_expect      = (w_ctr_addr == '0) ? '0 : r_wdata;
    assign bank_addr_rs1 = (r_state == ST_VERIFY) ? w_ctr_addr : r_rd_addr;
`else
    assign bank_addr_rs1 = r_rd_addr;
`endif

    regbank_addr_ctr #(
        .N (N)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_ctr_load),
        .i_start (host.cmd_addr),
        .i_len   (w_ctr_len),
        .i_step  (w_ctr_step),
        .o_addr  (w_ctr_addr),
        .o_last  (w_ctr_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctr_load  = 1'b0;
        w_ctr_step  = 1'b0;
        w_ctr_len   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        case (w_op)
                            OP_WRITE: begin
                                w_state_nxt = ST_WRITE;
                                w_ctr_load  = 1'b1;
                            end
                            OP_FILL: begin
                                w_state_nxt = ST_FILL;
                                w_ctr_load  = 1'b1;
                                w_ctr_len   = host.cmd_len;
                            end
                            default: w_state_nxt = ST_READ;
                        endcase
                    end
                end
            end
`ifdef REGBANK_WRITE_VERIFY_EN
            ST_WRITE:  w_state_nxt = ST_VERIFY;
            ST_FILL:   w_state_nxt = ST_VERIFY;
            // Step only after the read-back so VERIFY sees the written address.
            ST_VERIFY: begin
                if (w_ctr_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_FILL;
                    w_ctr_step  = 1'b1;
                end
            end
`else
            ST_WRITE:  w_state_nxt = ST_RESP;
            ST_FILL: begin
                if (w_ctr_last) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_ctr_step  = 1'b1;
                end
            end
            ST_VERIFY: w_state_nxt = ST_RESP;
`endif
            ST_READ:   w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (host.resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdata     <= '0;
            r_rd_addr   <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_resp_data <= '0;
                r_resp_err  <= w_reject;
                if (!w_reject && (w_op == OP_WRITE || w_op == OP_FILL)) begin
                    r_wdata <= host.cmd_data;
                end
                if (!w_reject && w_op == OP_READ) begin
                    r_rd_addr <= host.cmd_addr;
                end
            end
            if (r_state == ST_READ) begin
                r_resp_data <= bank_rs1;
            end
`ifdef REGBANK_WRITE_VERIFY_EN
            if (r_state == ST_VERIFY && bank_rs1 != w_expect) begin
                r_resp_err <= 1'b1;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_regbank_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_regbank_initiator
// Brief    : Scoreboard bench for regbank_initiator (N=32 and N=16 instances).
// Revision : 1.0  initial release
// ============================================================================
module tb_regbank_initiator;
    import regbank_pkg::*;

`ifdef REGBANK_WRITE_VERIFY_EN
    localparam int LAT_WR  = 3;
    localparam int WR_STEP = 2;
`else
    localparam int LAT_WR  = 2;
    localparam int WR_STEP = 1;
`endif
    localparam int LAT_RD  = 2;
    localparam int LAT_REJ = 1;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          vcyc;
        string       name;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regbank_initiator_if #(.W(16)) ifa ();
    regbank_initiator_if #(.W(16)) ifb ();

    logic [4:0]  a_addr_rd, a_addr_rs1, b_addr_rd, b_addr_rs1;
    logic [15:0] a_data_in, a_rs1, b_data_in, b_rs1;
    logic        a_we, b_we, a_busy, b_busy;
    logic [15:0] mem_a [32] = '{default: 16'h0};
    logic [15:0] mem_b [32] = '{default: 16'h0};

    regbank_initiator #(.N(32), .W(16)) u_dut_a (
        .clk(clk), .rst(rst), .host(ifa),
        .bank_addr_rd(a_addr_rd), .bank_data_in(a_data_in), .bank_we(a_we),
        .bank_addr_rs1(a_addr_rs1), .bank_rs1(a_rs1), .busy(a_busy)
    );

    regbank_initiator #(.N(16), .W(16)) u_dut_b (
        .clk(clk), .rst(rst), .host(ifb),
        .bank_addr_rd(b_addr_rd), .bank_data_in(b_data_in), .bank_we(b_we),
        .bank_addr_rs1(b_addr_rs1), .bank_rs1(b_rs1), .busy(b_busy)
    );

    // Register bank models: combinational read, address 0 reads as zero.
    always @(posedge clk) if (a_we) mem_a[a_addr_rd] <= a_data_in;
    always @(posedge clk) if (b_we) mem_b[b_addr_rd] <= b_data_in;
    assign a_rs1 = (a_addr_rs1 == 5'd0) ? 16'h0 : mem_a[a_addr_rs1];
    assign b_rs1 = (b_addr_rs1 == 5'd0) ? 16'h0 : mem_b[b_addr_rs1];

    exp_t q_a[$];
    exp_t q_b[$];
    wr_t  log_a[$];
    wr_t  log_b[$];

    always @(negedge clk) if (a_we) log_a.push_back('{addr: a_addr_rd, data: a_data_in, cyc: cyc});
    always @(negedge clk) if (b_we) log_b.push_back('{addr: b_addr_rd, data: b_data_in, cyc: cyc});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Response monitors: note first valid cycle and values, compare on handshake.
    bit          seen_a = 1'b0, seen_b = 1'b0;
    int          first_a, first_b;
    logic [15:0] d0_a, d0_b;
    exp_t        ea, eb;

    always @(negedge clk) begin
        if (rst) begin
            seen_a = 1'b0;
        end else if (ifa.resp_valid) begin
            if (!seen_a) begin
                seen_a = 1'b1;
                first_a = cyc;
                d0_a = ifa.resp_data;
            end
            if (ifa.resp_ready) begin
                seen_a = 1'b0;
                check("a_resp_pending", (q_a.size() != 0), 1);
                if (q_a.size() != 0) begin
                    ea = q_a.pop_front();
                    check({ea.name, "_data"}, ifa.resp_data, ea.data);
                    check({ea.name, "_err"}, ifa.resp_err, ea.err);
                    check({ea.name, "_latency_cyc"}, first_a, ea.vcyc);
                    check({ea.name, "_stable"}, ifa.resp_data, d0_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            seen_b = 1'b0;
        end else if (ifb.resp_valid) begin
            if (!seen_b) begin
                seen_b = 1'b1;
                first_b = cyc;
                d0_b = ifb.resp_data;
            end
            if (ifb.resp_ready) begin
                seen_b = 1'b0;
                check("b_resp_pending", (q_b.size() != 0), 1);
                if (q_b.size() != 0) begin
                    eb = q_b.pop_front();
                    check({eb.name, "_data"}, ifb.resp_data, eb.data);
                    check({eb.name, "_err"}, ifb.resp_err, eb.err);
                    check({eb.name, "_latency_cyc"}, first_b, eb.vcyc);
                    check({eb.name, "_stable"}, ifb.resp_data, d0_b);
                end
            end
        end
    end

    task automatic send(input int dut, input logic [1:0] op, input logic [4:0] addr,
                        input logic [4:0] len, input logic [15:0] data,
                        input logic [15:0] edata, input logic eerr, input int lat,
                        input bit push, input string name, output int tacc);
        int   bound = 0;
        logic rdy;
        exp_t e;
        @(negedge clk);
        if (dut == 0) begin
            ifa.cmd_valid = 1'b1; ifa.cmd_op = op; ifa.cmd_addr = addr;
            ifa.cmd_len = len; ifa.cmd_data = data;
            log_a.delete();
        end else begin
            ifb.cmd_valid = 1'b1; ifb.cmd_op = op; ifb.cmd_addr = addr;
            ifb.cmd_len = len; ifb.cmd_data = data;
            log_b.delete();
        end
        rdy = (dut == 0) ? ifa.cmd_ready : ifb.cmd_ready;
        while (!rdy && bound < 50) begin
            @(negedge clk);
            bound++;
            rdy = (dut == 0) ? ifa.cmd_ready : ifb.cmd_ready;
        end
        check({name, "_accepted"}, rdy, 1);
        tacc = cyc + 1;
        e.data = edata; e.err = eerr; e.vcyc = tacc + lat - 1; e.name = name;
        if (push && rdy) begin
            if (dut == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        @(posedge clk);
        #1;
        ifa.cmd_valid = 1'b0;
        ifb.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int dut, input string name);
        int bound = 0;
        while (((dut == 0) ? q_a.size() : q_b.size()) != 0 && bound < 100) begin
            @(negedge clk);
            bound++;
        end
        check({name, "_completed"}, (dut == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    task automatic txn(input int dut, input logic [1:0] op, input logic [4:0] addr,
                       input logic [4:0] len, input logic [15:0] data,
                       input logic [15:0] edata, input logic eerr, input int lat,
                       input string name, output int tacc);
        send(dut, op, addr, len, data, edata, eerr, lat, 1'b1, name, tacc);
        wait_done(dut, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          nwe;
        int          bound;
        logic [4:0]  fa [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        logic [4:0]  fb [4] = '{5'd14, 5'd15, 5'd0, 5'd1};

        ifa.cmd_valid = 0; ifa.cmd_op = 0; ifa.cmd_addr = 0; ifa.cmd_len = 0;
        ifa.cmd_data = 0; ifa.resp_ready = 1;
        ifb.cmd_valid = 0; ifb.cmd_op = 0; ifb.cmd_addr = 0; ifb.cmd_len = 0;
        ifb.cmd_data = 0; ifb.resp_ready = 1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", ifa.cmd_ready, 0);
        check("rst_resp_valid", ifa.resp_valid, 0);
        check("rst_resp_data", ifa.resp_data, 0);
        check("rst_resp_err", ifa.resp_err, 0);
        check("rst_bank_we", a_we, 0);
        check("rst_addr_rd", a_addr_rd, 0);
        check("rst_data_in", a_data_in, 0);
        check("rst_addr_rs1", a_addr_rs1, 0);
        check("rst_busy", a_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", ifa.cmd_ready, 1);

        // WRITE then READ back
        txn(0, OP_WRITE, 5'd5, 5'd0, 16'hBEEF, 16'h0, 1'b0, LAT_WR, "wr5", t);
        check("wr5_we_cycles", log_a.size(), 1);
        if (log_a.size() == 1) begin
            check("wr5_addr", log_a[0].addr, 5);
            check("wr5_wdata", log_a[0].data, 16'hBEEF);
            check("wr5_we_cyc", log_a[0].cyc, t);
        end
        txn(0, OP_READ, 5'd5, 5'd0, 16'h0, 16'hBEEF, 1'b0, LAT_RD, "rd5", t);

        // Address 0 always reads zero
        txn(0, OP_WRITE, 5'd0, 5'd0, 16'h1234, 16'h0, 1'b0, LAT_WR, "wr0", t);
        txn(0, OP_READ, 5'd0, 5'd0, 16'h0, 16'h0, 1'b0, LAT_RD, "rd0", t);

        // FILL wrapping 30,31,0,1
        txn(0, OP_FILL, 5'd30, 5'd3, 16'h00AA, 16'h0, 1'b0, LAT_WR + WR_STEP * 3, "fill30", t);
        check("fill30_we_cycles", log_a.size(), 4);
        for (int k = 0; k < 4 && k < log_a.size(); k++) begin
            check($sformatf("fill30_addr%0d", k), log_a[k].addr, fa[k]);
            check($sformatf("fill30_wdata%0d", k), log_a[k].data, 16'h00AA);
            check($sformatf("fill30_cyc%0d", k), log_a[k].cyc, t + k * WR_STEP);
        end
        txn(0, OP_READ, 5'd31, 5'd0, 16'h0, 16'h00AA, 1'b0, LAT_RD, "rd31", t);
        txn(0, OP_READ, 5'd1, 5'd0, 16'h0, 16'h00AA, 1'b0, LAT_RD, "rd1", t);
        txn(0, OP_READ, 5'd2, 5'd0, 16'h0, 16'h0, 1'b0, LAT_RD, "rd2", t);

        // Reserved op rejected, no bank write, data zero
        txn(0, OP_RSVD, 5'd3, 5'd0, 16'hFFFF, 16'h0, 1'b1, LAT_REJ, "rsvd", t);
        check("rsvd_no_write", log_a.size(), 0);

        // Back-pressured response
        txn(0, OP_WRITE, 5'd7, 5'd0, 16'hC0DE, 16'h0, 1'b0, LAT_WR, "wr7", t);
        ifa.resp_ready = 1'b0;
        send(0, OP_READ, 5'd7, 5'd0, 16'h0, 16'hC0DE, 1'b0, LAT_RD, 1'b1, "hold7", t);
        bound = 0;
        while (!ifa.resp_valid && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        check("hold7_valid_seen", ifa.resp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold7_valid_held", ifa.resp_valid, 1);
            check("hold7_data_held", ifa.resp_data, 16'hC0DE);
            check("hold7_cmd_ready", ifa.cmd_ready, 0);
        end
        ifa.resp_ready = 1'b1;
        wait_done(0, "hold7");
        txn(0, OP_READ, 5'd5, 5'd0, 16'h0, 16'hBEEF, 1'b0, LAT_RD, "rd5_after_hold", t);

        // Reset during the third write of FILL 8 len 7
        send(0, OP_FILL, 5'd8, 5'd7, 16'h7777, 16'h0, 1'b0, 0, 1'b0, "fill_rst", t);
        nwe = 0;
        bound = 0;
        while (nwe < 3 && bound < 40) begin
            @(negedge clk);
            if (a_we) nwe++;
            bound++;
        end
        check("fill_rst_third_write", nwe, 3);
        rst = 1'b1;
        @(negedge clk);
        check("fill_rst_we", a_we, 0);
        check("fill_rst_resp_valid", ifa.resp_valid, 0);
        check("fill_rst_busy", a_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("fill_rst_cmd_ready", ifa.cmd_ready, 1);
        check("fill_rst_write_count", log_a.size(), 3);
        txn(0, OP_READ, 5'd9, 5'd0, 16'h0, 16'h7777, 1'b0, LAT_RD, "rd9", t);
        txn(0, OP_READ, 5'd11, 5'd0, 16'h0, 16'h0, 1'b0, LAT_RD, "rd11", t);
        txn(0, OP_READ, 5'd15, 5'd0, 16'h0, 16'h0, 1'b0, LAT_RD, "rd15", t);

        // N=16 instance: out-of-range rejects and modulo-16 wrap
        txn(1, OP_READ, 5'd20, 5'd0, 16'h0, 16'h0, 1'b1, LAT_REJ, "b_rd20", t);
        check("b_rd20_no_write", log_b.size(), 0);
        txn(1, OP_WRITE, 5'd16, 5'd0, 16'h1111, 16'h0, 1'b1, LAT_REJ, "b_wr16", t);
        check("b_wr16_no_write", log_b.size(), 0);
        txn(1, OP_FILL, 5'd14, 5'd3, 16'h5A5A, 16'h0, 1'b0, LAT_WR + WR_STEP * 3, "b_fill14", t);
        check("b_fill14_we_cycles", log_b.size(), 4);
        for (int k = 0; k < 4 && k < log_b.size(); k++) begin
            check($sformatf("b_fill14_addr%0d", k), log_b[k].addr, fb[k]);
        end
        txn(1, OP_READ, 5'd15, 5'd0, 16'h0, 16'h5A5A, 1'b0, LAT_RD, "b_rd15", t);

        repeat (2) @(negedge clk);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
